fb_muldiv_ctrl: RTL

Multi-cycle sequencer for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the Firebird execute stage. It takes over the M-extension one-hot control bits from the ALU control word and runs an iterative 32-step shift-add multiply or restoring divide. While it works, it stalls the pipeline through `busy`, then returns a registered result with a one-cycle `done` pulse. The single-cycle ALU path keeps all non-M operations.

---
 rtl/fb_muldiv_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fb_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add or restoring divide.
// Ports: clk, rst (async high), start/op/op1/op2/flush in; busy, done, result out.
module fb_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int W = WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [2:0]   state_q, state_d;
  logic [7:0]   op_q, op_d, op_pri;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         n1_q, n1_d, n2_q, n2_d;

  logic accept, is_mul, is_div, sgn1, sgn2, sdiv, want_q;
  logic [W:0]     mul_sum, div_sh, div_df;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rmd;

  // Highest set bit wins when several op bits are asserted.
  always_comb begin
    op_pri = '0;
    priority case (1'b1)
      op[7]:   op_pri = 8'h80;
      op[6]:   op_pri = 8'h40;
      op[5]:   op_pri = 8'h20;
      op[4]:   op_pri = 8'h10;
      op[3]:   op_pri = 8'h08;
      op[2]:   op_pri = 8'h04;
      op[1]:   op_pri = 8'h02;
      op[0]:   op_pri = 8'h01;
      default: op_pri = '0;
    endcase
  end

  assign accept = start && (op != 8'h00) && !flush;
  assign is_mul = |op_q[7:4];
  assign is_div = |op_q[3:0];
  assign sgn1   = op_q[6] | op_q[5] | op_q[3] | op_q[1];
  assign sgn2   = op_q[6] | op_q[3] | op_q[1];
  assign sdiv   = op_q[3] | op_q[1];
  assign want_q = op_q[3] | op_q[2];

  // Multiply: right-shifting accumulator, multiplier bits consumed from b_q.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (b_q[0] ? a_q : '0)};
  // Divide: remainder in acc_q low half, quotient shifts into a_q.
  assign div_sh  = {acc_q[W-1:0], a_q[W-1]};
  assign div_df  = div_sh - {1'b0, b_q};

  assign prod = (n1_q ^ n2_q) ? -acc_q : acc_q;
  assign quo  = (n1_q ^ n2_q) ? -a_q : a_q;
  assign rmd  = n1_q ? -acc_q[W-1:0] : acc_q[W-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_PREP;
          op_d    = op_pri;
          a_d     = op1;
          b_d     = op2;
        end
      end
      S_PREP: begin
        n1_d    = sgn1 & a_q[W-1];
        n2_d    = sgn2 & b_q[W-1];
        a_d     = n1_d ? -a_q : a_q;
        b_d     = n2_d ? -b_q : b_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
        if (is_div && b_q == '0) begin
          res_d   = want_q ? '1 : a_q;
          state_d = S_DONE;
        end else if (sdiv && a_q == MIN_NEG && b_q == '1) begin
          res_d   = want_q ? MIN_NEG : '0;
          state_d = S_DONE;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_mul) begin
          acc_d = {mul_sum, acc_q[W-1:1]};
          b_d   = b_q >> 1;
        end else begin
          acc_d = {acc_q[2*W-1:W],
                   (div_df[W] ? div_sh[W-1:0] : div_df[W-1:0])};
          a_d   = {a_q[W-2:0], ~div_df[W]};
        end
        if (cnt_q == 5'd31) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (is_mul) res_d = op_q[7] ? prod[W-1:0] : prod[2*W-1:W];
        else        res_d = want_q ? quo : rmd;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      n1_q    <= 1'b0;
      n2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
    end
  end

  // Stall the issuing instruction in its own cycle; never while flushing.
  assign busy = !rst && !flush &&
                (((state_q == S_IDLE || state_q == S_DONE) && accept) ||
                 state_q == S_PREP || state_q == S_CALC ||
                 state_q == S_FIXUP);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

endmodule
